// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-bus UART: register map, status bits, FSM states.
package cpu_bus_pkg;
  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_DIVL = 2'd2;
  localparam logic [1:0] UART_DIVH = 2'd3;

  localparam int ST_RX_VALID  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_BUSY   = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_DROP   = 6;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/bus_uart_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module bus_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // a push into a full FIFO is lost even if a pop frees a slot this cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr[AW-1:0]];

  // pointer update; wrap is natural through the extra MSB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART on the 6502 bus: TX FIFO, one-byte RX hold, status, divisor.
module bus_uart
  import cpu_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h6000,
  parameter logic [15:0] DIV_RESET  = 16'd433,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adr_bus,
  input  logic        RW,
  input  logic [7:0]  data_wr,
  output logic        sel,
  output logic [7:0]  rdata,
  output logic        tx,
  input  logic        rx
);
  logic        rd, wr, rd_data;
  logic [1:0]  off;
  logic [15:0] div;
  logic [7:0]  rx_hold, rd_mux, status;
  logic        rx_valid, rx_ovr, frame_err, tx_drop;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;

  uart_state_t tx_st, tx_st_d, rx_st, rx_st_d;
  logic [15:0] tx_cnt, tx_cnt_d, rx_cnt, rx_cnt_d;
  logic [2:0]  tx_bit, tx_bit_d, rx_bit, rx_bit_d;
  logic [7:0]  tx_sh, tx_sh_d, rx_sh, rx_sh_d;
  logic        tx_d, rx_s1, rx_s2, rx_s3, rx_fall, rx_done, rx_bad;

  assign sel     = (adr_bus[15:2] == BASE_ADDR[15:2]);
  assign off     = adr_bus[1:0];
  assign rd      = sel & RW;
  assign wr      = sel & ~RW;
  assign rd_data = rd && (off == UART_DATA);
  assign rx_fall = rx_s3 & ~rx_s2;
  assign status  = {1'b0, tx_drop, frame_err, rx_ovr, (tx_st != IDLE),
                    fifo_empty, fifo_full, rx_valid};

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk), .reset(reset), .push(wr && (off == UART_DATA)), .din(data_wr),
    .pop(fifo_pop), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty));

  // read data select
  always_comb begin
    rd_mux = rx_hold;
    case (off)
      UART_STAT: rd_mux = status;
      UART_DIVL: rd_mux = div[7:0];
      UART_DIVH: rd_mux = div[15:8];
      default:   rd_mux = rx_hold;
    endcase
  end

  // TX next state; tx is registered from the next state so it never glitches
  always_comb begin
    tx_st_d = tx_st; tx_cnt_d = tx_cnt; tx_bit_d = tx_bit; tx_sh_d = tx_sh;
    fifo_pop = 1'b0;
    case (tx_st)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1; tx_sh_d = fifo_dout; tx_cnt_d = div; tx_st_d = START;
      end
      START: if (tx_cnt == '0) begin
        tx_cnt_d = div; tx_bit_d = '0; tx_st_d = DATA;
      end else tx_cnt_d = tx_cnt - 16'd1;
      DATA: if (tx_cnt == '0) begin
        tx_cnt_d = div;
        if (tx_bit == 3'd7) tx_st_d = STOP;
        else begin tx_bit_d = tx_bit + 3'd1; tx_sh_d = tx_sh >> 1; end
      end else tx_cnt_d = tx_cnt - 16'd1;
      STOP: if (tx_cnt == '0) begin
        // chain straight into the next start bit when more data is queued
        if (!fifo_empty) begin
          fifo_pop = 1'b1; tx_sh_d = fifo_dout; tx_cnt_d = div; tx_st_d = START;
        end else tx_st_d = IDLE;
      end else tx_cnt_d = tx_cnt - 16'd1;
      default: tx_st_d = IDLE;
    endcase
    tx_d = 1'b1;
    if (tx_st_d == START)     tx_d = 1'b0;
    else if (tx_st_d == DATA) tx_d = tx_sh_d[0];
  end

  // RX next state; start is qualified at half-bit, then sampled at bit centres
  always_comb begin
    rx_st_d = rx_st; rx_cnt_d = rx_cnt; rx_bit_d = rx_bit; rx_sh_d = rx_sh;
    rx_done = 1'b0; rx_bad = 1'b0;
    case (rx_st)
      IDLE: if (rx_fall) begin rx_cnt_d = div >> 1; rx_st_d = START; end
      START: if (rx_cnt == '0) begin
        if (rx_s2) rx_st_d = IDLE;
        else begin rx_cnt_d = div; rx_bit_d = '0; rx_st_d = DATA; end
      end else rx_cnt_d = rx_cnt - 16'd1;
      DATA: if (rx_cnt == '0) begin
        rx_sh_d = {rx_s2, rx_sh[7:1]}; rx_cnt_d = div;
        if (rx_bit == 3'd7) rx_st_d = STOP;
        else rx_bit_d = rx_bit + 3'd1;
      end else rx_cnt_d = rx_cnt - 16'd1;
      STOP: if (rx_cnt == '0) begin
        rx_done = rx_s2; rx_bad = ~rx_s2; rx_st_d = IDLE;
      end else rx_cnt_d = rx_cnt - 16'd1;
      default: rx_st_d = IDLE;
    endcase
  end

  // FSM state, synchronizer and serial output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st <= IDLE; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0; tx <= 1'b1;
      rx_st <= IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_s3 <= 1'b1;
    end else begin
      tx_st <= tx_st_d; tx_cnt <= tx_cnt_d; tx_bit <= tx_bit_d; tx_sh <= tx_sh_d; tx <= tx_d;
      rx_st <= rx_st_d; rx_cnt <= rx_cnt_d; rx_bit <= rx_bit_d; rx_sh <= rx_sh_d;
      rx_s1 <= rx; rx_s2 <= rx_s1; rx_s3 <= rx_s2;
    end
  end

  // bus-visible registers; sticky sets are placed after clears so a set wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0; div <= DIV_RESET; rx_hold <= '0; rx_valid <= 1'b0;
      rx_ovr <= 1'b0; frame_err <= 1'b0; tx_drop <= 1'b0;
    end else begin
      if (rd) rdata <= rd_mux;
      if (wr && off == UART_DIVL) div[7:0]  <= data_wr;
      if (wr && off == UART_DIVH) div[15:8] <= data_wr;
      if (wr && off == UART_STAT) begin
        if (data_wr[ST_RX_OVR])    rx_ovr    <= 1'b0;
        if (data_wr[ST_FRAME_ERR]) frame_err <= 1'b0;
        if (data_wr[ST_TX_DROP])   tx_drop   <= 1'b0;
      end
      if (wr && off == UART_DATA && fifo_full) tx_drop <= 1'b1;
      if (rx_bad) frame_err <= 1'b1;
      // a read racing a completion returns the old byte and is not an overrun
      if (rx_done) begin
        rx_hold <= rx_sh; rx_valid <= 1'b1;
        if (rx_valid && !rd_data) rx_ovr <= 1'b1;
      end else if (rd_data) rx_valid <= 1'b0;
    end
  end
endmodule

// File: doc/bus_uart.md
Name: bus_uart

Overview:
- Memory-mapped UART peripheral on the 6502 CPU bus, directly downstream of the CPU.
- Decodes `adr_bus`, `RW` and `data_bus_out` from the CPU core.
- Supplies read data for the system data-bus mux that feeds the CPU's `data_bus_in`.
- Provides a 4-register interface: a TX FIFO, a single-byte RX holding register, status, and a programmable baud divisor.

Parameters:
- `BASE_ADDR`, 16'h6000, base of the 4-byte register window; bits [1:0] are ignored.
- `DIV_RESET`, 16'd433, reset value of the divisor; clocks per bit = DIV+1.
- `FIFO_DEPTH`, 4, TX FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; CPU acts on negedge, this block acts on posedge only.
- `reset`  in  1  asynchronous, active-high reset.
- `adr_bus`  in  16  CPU address bus.
- `RW`  in  1  1 = read, 0 = write.
- `data_wr`  in  8  CPU `data_bus_out`.
- `sel`  out  1  combinational: `adr_bus[15:2] == BASE_ADDR[15:2]`.
- `rdata`  out  8  registered read data, to the data-bus mux.
- `tx`  out  1  serial output, idle high.
- `rx`  in  1  serial input, asynchronous.

Behaviour:
- **Access timing.** CPU drives address/RW/data at negedge; each address is held for exactly one clock.
  - The access point is the posedge inside that period.
  - Read: at posedge with `sel & RW`, `rdata <=` selected register and any read side effect occurs; CPU samples `rdata` at the following negedge.
  - Write: at posedge with `sel & ~RW`, `data_wr` is captured.
  - `rdata` holds its value when not read.
- **Registers** (offset = `adr_bus[1:0]`):
  - 0 DATA. R: returns `rx_hold`, clears `rx_valid`. W: push to TX FIFO; if full, byte dropped and `tx_drop` set.
  - 1 STATUS. R: bit0 `rx_valid`, bit1 `tx_full`, bit2 `tx_empty`, bit3 `tx_busy`, bit4 `rx_ovr`, bit5 `frame_err`, bit6 `tx_drop`, bit7 0. No read side effect. W: each 1 in bits 4–6 clears that sticky bit; other bits ignored.
  - 2/3 DIV_LO/DIV_HI: R/W divisor bytes. A new value affects the next counter reload only; the current bit period is unchanged.
- **Reset values:** `rdata`=0, `tx`=1, FIFO empty, `rx_valid`=0, all sticky bits 0, DIV=`DIV_RESET`, TX and RX FSMs in IDLE. Reset mid-frame aborts immediately; `tx` returns to 1 asynchronously.
- **TX FSM:** IDLE→START→DATA→STOP→IDLE.
  - IDLE: when FIFO is non-empty, pop the head into the shift register and go to START with the bit counter loaded to DIV.
  - Each state lasts DIV+1 clocks.
  - DATA sends 8 bits LSB first; STOP drives 1 for one bit.
  - STOP→START back-to-back if the FIFO is non-empty at the end of STOP (no idle gap).
  - `tx_busy` = state≠IDLE.
  - 8N1 frame length is exactly 10·(DIV+1) clocks.
- **TX FIFO:** circular buffer with `$clog2(FIFO_DEPTH)+1`-bit read/write pointers; pointers wrap naturally.
  - Full = MSBs differ and low bits are equal.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: both occur, count unchanged.
  - Push while full is dropped even if a pop happens in the same cycle.
- **RX:**
  - 2-flop synchronizer, resets to 1.
  - IDLE: a synchronized falling edge loads the counter with DIV>>1 and enters START.
  - START: at half-bit, if the line is high → IDLE (glitch rejected); else DATA.
  - DATA: 8 samples at bit centres, LSB first.
  - STOP: sample at centre.
    - Stop=0: `frame_err` set, byte discarded.
    - Stop=1 and `rx_valid`=1: `rx_ovr` set, `rx_hold` overwritten.
    - Always: `rx_hold` loaded, `rx_valid`=1.
  - Completion on the same posedge as a DATA read: `rdata` gets the old byte, `rx_hold` gets the new byte, `rx_valid` stays 1, no overrun.
  - Return to IDLE immediately after the stop sample.

Decomposition:
- `cpu_bus_pkg`:
  - register offset localparams (`UART_DATA`=0, `UART_STAT`=1, `UART_DIVL`=2, `UART_DIVH`=3);
  - status bit indices;
  - `uart_state_t` enum {IDLE, START, DATA, STOP}, shared by the TX and RX FSMs.
- Sub-module `bus_uart_fifo`: parameterised 8-bit synchronous FIFO with push/pop/full/empty and async active-high reset. TX and RX FSMs stay inline.

Test Plan:
- Reset: assert `reset` mid-TX → `tx`=1 immediately; STATUS reads 8'h04; DIV reads 433 (LO 8'hB1, HI 8'h01).
- TX timing: DIV=3, write 8'hA5 to 16'h6000 → start bit 4 clocks low, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, stop high; total 40 clocks.
- FIFO full: DIV=3, write 5 bytes back to back → first pops to TX, next 4 fill the FIFO; STATUS bit1=1; 6th write sets bit6; write 8'h40 to STATUS clears it.
- RX: DIV=7, drive frame 8'h3C at 8 clocks/bit → `rx_valid`=1; DATA read returns 8'h3C; next STATUS bit0=0.
- Errors: two frames without a read → `rx_ovr`=1, DATA=second byte; frame with stop=0 → `frame_err`=1, `rx_valid` unchanged; 2-clock low glitch → no reception.
- Simultaneous: read DATA on the exact posedge a new byte completes → returns old byte; STATUS bit0=1, bit4=0.
